ls_program_loader: RTL and testbench

Writer-side counterpart to the instruction fetch path. It accepts a stream of 32-bit SPU instruction words over a valid/ready handshake and packs them into 128-bit quadwords. Each quadword is written into the local store through the ls_addr / ls_data_wr / ls_wr_en write port. While loading, it holds the core via core_hold; on completion it releases the core with a start PC.

---
 rtl/ls_program_loader_pkg.sv | 20 ++
 rtl/ls_quad_packer.sv | 60 ++++++
 rtl/ls_program_loader.sv | 165 ++++++++++++++++
 tb/tb_ls_program_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_program_loader_pkg.sv
// Shared types and constants for the local-store program loader.
package ls_program_loader_pkg;

  localparam int unsigned LS_QUAD_BYTES     = 16;
  localparam int unsigned LS_WORDS_PER_QUAD = 4;
  localparam int unsigned LS_WORD_W         = 32;
  localparam int unsigned LS_QUAD_W         = 128;
  localparam int unsigned LS_ADDR_W         = 32;

  localparam logic [31:0] SPU_NOP_WORD = 32'h4020_0000;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FILL,
    WRITE,
    DONE
  } loader_state_e;

endpackage

// File: rtl/ls_quad_packer.sv
// Packs 32-bit words MSB-first into a 128-bit quadword register.
// LS_LOADER_NOP_PAD_EN: pad a final partial quad with SPU nops instead of zeros.
module ls_quad_packer
  import ls_program_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [0:31]  word,
  input  logic         clear,
  input  logic         pad,
  output logic         full,
  output logic [0:127] quad
);

`ifdef LS_LOADER_NOP_PAD_EN
  localparam logic [0:31] PAD_WORD = SPU_NOP_WORD;
`else
  localparam logic [0:31] PAD_WORD = 32'h0000_0000;
`endif

  logic [1:0]   idx_q;
  logic [1:0]   idx_d;
  logic [0:127] pack_q;
  logic [0:127] pack_d;

  // Word k lands in bits [32k:32k+31]; pad fills every slot above the last word.
  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    if (clear) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (load) begin
      for (int unsigned k = 0; k < LS_WORDS_PER_QUAD; k++) begin
        if (2'(k) == idx_q) begin
          pack_d[k*LS_WORD_W +: LS_WORD_W] = word;
        end else if (pad && (2'(k) > idx_q)) begin
          pack_d[k*LS_WORD_W +: LS_WORD_W] = PAD_WORD;
        end
      end
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end

  // High when the next loaded word completes the quad.
  assign full = (idx_q == 2'(LS_WORDS_PER_QUAD - 1));
  assign quad = pack_q;

endmodule

// File: rtl/ls_program_loader.sv
// Streams 32-bit instruction words into local store as quadwords, holding the core meanwhile.
// Optional build macro LS_LOADER_NOP_PAD_EN selects nop padding in ls_quad_packer.
module ls_program_loader
  import ls_program_loader_pkg::*;
#(
  parameter int unsigned LS_BYTES = 32768,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:31]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      in_data,
  output logic [0:31]      ls_addr,
  output logic [0:127]     ls_data_wr,
  output logic             ls_wr_en,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [0:31]      pc_start
);

  loader_state_e state_q;
  loader_state_e state_d;

  logic [LS_ADDR_W-1:0] quad_addr_q;
  logic [LS_ADDR_W-1:0] quad_addr_d;
  logic [CNT_W-1:0]     rem_q;
  logic [CNT_W-1:0]     rem_d;
  logic [LS_ADDR_W-1:0] aligned_base;
  logic [LS_ADDR_W:0]   end_addr;
  logic                 range_bad;
  logic                 accept;

  logic [0:31] ls_addr_d;
  logic [0:31] pc_d;
  logic        err_d;
  logic        busy_d;
  logic        ready_d;
  logic        wr_en_d;
  logic        done_d;

  logic         pk_load;
  logic         pk_clear;
  logic         pk_pad;
  logic         pk_full;
  logic [0:127] pk_quad;

  assign aligned_base = base_addr & ~LS_ADDR_W'(LS_QUAD_BYTES - 1);
  assign accept       = in_valid && in_ready;

  // Range check at one extra bit so a load running past the top can never wrap.
  assign end_addr  = (LS_ADDR_W+1)'(quad_addr_q) + ((LS_ADDR_W+1)'(rem_q) << 2);
  assign range_bad = end_addr > (LS_ADDR_W+1)'(LS_BYTES);

  always_comb begin
    state_d     = state_q;
    quad_addr_d = quad_addr_q;
    rem_d       = rem_q;
    ls_addr_d   = ls_addr;
    pc_d        = pc_start;
    err_d       = err;
    pk_load     = 1'b0;
    pk_clear    = 1'b0;
    pk_pad      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CHECK;
          quad_addr_d = aligned_base;
          rem_d       = word_count;
          pc_d        = aligned_base;
          err_d       = 1'b0;
          pk_clear    = 1'b1;
        end
      end
      CHECK: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (range_bad) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          pk_load = 1'b1;
          pk_pad  = (rem_q == CNT_W'(1));
          rem_d   = rem_q - CNT_W'(1);
          if (pk_full || (rem_q == CNT_W'(1))) begin
            state_d   = WRITE;
            ls_addr_d = quad_addr_q;
          end
        end
      end
      WRITE: begin
        pk_clear    = 1'b1;
        quad_addr_d = quad_addr_q + LS_ADDR_W'(LS_QUAD_BYTES);
        state_d     = (rem_q == '0) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake and status outputs are registered versions of the next state.
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == FILL);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      quad_addr_q <= '0;
      rem_q       <= '0;
      ls_addr     <= '0;
      pc_start    <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      core_hold   <= 1'b0;
      in_ready    <= 1'b0;
      ls_wr_en    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      quad_addr_q <= quad_addr_d;
      rem_q       <= rem_d;
      ls_addr     <= ls_addr_d;
      pc_start    <= pc_d;
      err         <= err_d;
      busy        <= busy_d;
      core_hold   <= busy_d;
      in_ready    <= ready_d;
      ls_wr_en    <= wr_en_d;
      done        <= done_d;
    end
  end

  ls_quad_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .load  (pk_load),
    .word  (in_data),
    .clear (pk_clear),
    .pad   (pk_pad),
    .full  (pk_full),
    .quad  (pk_quad)
  );

  // The pack register holds the finished quad for the whole WRITE cycle.
  assign ls_data_wr = pk_quad;

endmodule

// File: tb/tb_ls_program_loader.sv
// Self-checking bench for ls_program_loader: vector table, hand sequences and random loads vs a reference model.
module tb_ls_program_loader;

  localparam int unsigned LS_BYTES = 32768;
  localparam int unsigned CNT_W    = 16;

`ifdef LS_LOADER_NOP_PAD_EN
  localparam logic [31:0] PAD = 32'h4020_0000;
`else
  localparam logic [31:0] PAD = 32'h0000_0000;
`endif

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    int          count;
    bit          seq;
    bit          gaps;
    bit          inject;
    bit          exp_err;
    int          exp_nwr;
    int          exp_lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [0:31]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic             in_ready;
  logic [0:31]      in_data;
  logic [0:31]      ls_addr;
  logic [0:127]     ls_data_wr;
  logic             ls_wr_en;
  logic             core_hold;
  logic             busy;
  logic             done;
  logic             err;
  logic [0:31]      pc_start;

  int          checks = 0;
  int          errors = 0;
  int          overlap = 0;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] words[$];
  bit          exp_err;
  vec_t        tbl[8];

  always #5 clk = ~clk;

  ls_program_loader #(.LS_BYTES(LS_BYTES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ls_addr    (ls_addr),
    .ls_data_wr (ls_data_wr),
    .ls_wr_en   (ls_wr_en),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc_start   (pc_start)
  );

  // Write monitor: records every strobe and counts strobes that coincide with in_ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (ls_wr_en) got_q.push_back('{addr: ls_addr, data: ls_data_wr});
      if (ls_wr_en && in_ready) overlap++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: expected writes follow directly from base, count and the word stream.
  task automatic model_load(input logic [31:0] base, input int count);
    logic [31:0] ab;
    logic [32:0] endp;
    wr_t         w;
    exp_q.delete();
    exp_err = 1'b0;
    ab   = base & 32'hFFFF_FFF0;
    endp = {1'b0, ab} + 33'(count * 4);
    if (count == 0) return;
    if (endp > 33'(LS_BYTES)) begin
      exp_err = 1'b1;
      return;
    end
    for (int q = 0; q * 4 < count; q++) begin
      w.addr = ab + 32'(16 * q);
      w.data = '0;
      for (int k = 0; k < 4; k++)
        w.data[127 - 32*k -: 32] = (4*q + k < count) ? words[4*q + k] : PAD;
      exp_q.push_back(w);
    end
  endtask

  task automatic run_load(input logic [31:0] base, input int count, input bit seq,
                          input bit gaps, input bit inject, output int lat);
    int idx;
    bit pending;
    bit busy_low;
    words.delete();
    for (int i = 0; i < count; i++) words.push_back(seq ? 32'(i + 1) : $urandom);
    got_q.delete();
    overlap  = 0;
    idx      = 0;
    pending  = 1'b0;
    busy_low = 1'b0;
    lat      = -1;
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(count);
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pending) begin
        idx++;
        pending = 1'b0;
      end
      if (!busy || !core_hold) busy_low = 1'b1;
      if (done) begin
        lat = cyc;
        break;
      end
      if (inject && cyc == 4) begin
        start      = 1'b1;
        base_addr  = 32'h0;
        word_count = CNT_W'(1);
      end
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = (idx < count) ? words[idx] : 32'hDEAD_BEEF;
      pending  = in_valid && in_ready;
    end
    in_valid = 1'b0;
    chk("done_seen", 128'(lat > 0), 128'(1));
    chk("busy_hold_during_load", 128'(busy_low), 128'(0));
    chk("pc_start", 128'(pc_start), 128'(base & 32'hFFFF_FFF0));
    @(posedge clk); #1;
    chk("done_single_cycle", 128'(done), 128'(0));
    chk("busy_hold_drop", 128'({busy, core_hold}), 128'(0));
    chk("wr_en_with_ready", 128'(overlap), 128'(0));
    model_load(base, count);
    chk("err_sticky", 128'(err), 128'(exp_err));
    chk("num_writes", 128'(got_q.size()), 128'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      chk($sformatf("wr%0d_addr", j), 128'(got_q[j].addr), 128'(exp_q[j].addr));
      chk($sformatf("wr%0d_data", j), got_q[j].data, exp_q[j].data);
    end
  endtask

  initial begin
    int lat;
    int idx;
    bit pending;

    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_data    = '0;

    tbl[0] = '{32'h0000_0100,  8, 1'b1, 1'b0, 1'b0, 1'b0, 2, 12};
    tbl[1] = '{32'h0000_020F,  5, 1'b1, 1'b0, 1'b0, 1'b0, 2,  9};
    tbl[2] = '{32'h0000_0300,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  2};
    tbl[3] = '{32'h0000_7FF0,  5, 1'b0, 1'b0, 1'b0, 1'b1, 0,  2};
    tbl[4] = '{32'h0000_7FF0,  4, 1'b0, 1'b0, 1'b0, 1'b0, 1,  7};
    tbl[5] = '{32'hFFFF_FFF0,  1, 1'b0, 1'b0, 1'b0, 1'b1, 0,  2};
    tbl[6] = '{32'h0000_1000,  3, 1'b0, 1'b1, 1'b1, 1'b0, 1, -1};
    tbl[7] = '{32'h0000_0000, 13, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 128'({in_ready, ls_wr_en, core_hold, busy, done, err}), 128'(0));
    chk("reset_addr_pc", 128'({ls_addr, pc_start}), 128'(0));
    chk("reset_data", ls_data_wr, 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_load(tbl[i].base, tbl[i].count, tbl[i].seq, tbl[i].gaps, tbl[i].inject, lat);
      chk($sformatf("vec%0d_err", i), 128'(err), 128'(tbl[i].exp_err));
      chk($sformatf("vec%0d_nwr", i), 128'(got_q.size()), 128'(tbl[i].exp_nwr));
      if (tbl[i].exp_lat >= 0) chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      if (i == 0 && got_q.size() == 2) begin
        chk("vec0_q0_data", got_q[0].data, 128'h00000001_00000002_00000003_00000004);
        chk("vec0_q1_addr", 128'(got_q[1].addr), 128'h110);
        chk("vec0_q1_data", got_q[1].data, 128'h00000005_00000006_00000007_00000008);
      end
      if (i == 1 && got_q.size() == 2) begin
        chk("vec1_q0_addr", 128'(got_q[0].addr), 128'h200);
        chk("vec1_q1_pad", got_q[1].data, {32'h0000_0005, PAD, PAD, PAD});
      end
    end

    // Reset after 6 of 8 words: only the first quad may reach the local store.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(32'hA000_0000 + 32'(i));
    got_q.delete();
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = 32'h400;
    word_count = CNT_W'(8);
    idx        = 0;
    pending    = 1'b0;
    for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pending) begin
        idx++;
        pending = 1'b0;
      end
      if (idx < 6) begin
        in_valid = 1'b1;
        in_data  = words[idx];
        pending  = in_ready;
      end
    end
    chk("abort_reached_6_words", 128'(idx), 128'(6));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ctrl_zero", 128'({in_ready, ls_wr_en, core_hold, busy, done, err}), 128'(0));
    chk("abort_addr_pc_zero", 128'({ls_addr, pc_start}), 128'(0));
    chk("abort_data_zero", ls_data_wr, 128'(0));
    chk("abort_num_writes", 128'(got_q.size()), 128'(1));
    if (got_q.size() > 0) begin
      chk("abort_wr_addr", 128'(got_q[0].addr), 128'h400);
      chk("abort_wr_data", got_q[0].data, 128'hA0000000_A0000001_A0000002_A0000003);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_load(32'h0000_0840, 6, 1'b0, 1'b0, 1'b0, lat);
    chk("post_abort_latency", 128'(lat), 128'(10));

    // Random loads with handshake gaps and occasional stray start pulses.
    for (int r = 0; r < 25; r++) begin
      logic [31:0] b;
      int          c;
      c = $urandom_range(0, 40);
      if ($urandom_range(0, 4) == 0) b = 32'(LS_BYTES) - 32'($urandom_range(0, 160));
      else b = $urandom_range(0, LS_BYTES - 1);
      run_load(b, c, 1'b0, 1'b1, 1'($urandom_range(0, 1)), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
